fsm_ctrl: RTL and testbench

- Main link-layer control FSM.
- Sequences reset → init → idle/active, and captures the FIFO watermark thresholds during init.
- Distributes the captured thresholds to the main, VC0, VC1, D0 and D1 FIFOs.
- Watches the FIFO empty and error flags; it is the block that the existing stimulus generator drives and checks.

---
 rtl/fsm_ctrl.sv | 103 ++++++++++
 tb/tb_fsm_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fsm_ctrl.sv
// fsm_ctrl: link-layer control FSM with threshold capture and sticky FIFO error tracking; define FSM_ERR_RECOVER_EN to allow init to leave ERROR
module fsm_ctrl #(
  parameter int TW = 5,
  parameter int NF = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init,
  input  logic [TW-1:0] main_fifo_low,
  input  logic [TW-1:0] main_fifo_high,
  input  logic [TW-1:0] Vco_low,
  input  logic [TW-1:0] Vco_high,
  input  logic [TW-1:0] Vc1_low,
  input  logic [TW-1:0] Vc1_high,
  input  logic [TW-1:0] Do_low,
  input  logic [TW-1:0] Do_high,
  input  logic [TW-1:0] D1_low,
  input  logic [TW-1:0] D1_high,
  input  logic [NF-1:0] empties,
  input  logic [NF-1:0] errors,
  output logic [TW-1:0] main_low_out,
  output logic [TW-1:0] main_high_out,
  output logic [TW-1:0] vc0_low_out,
  output logic [TW-1:0] vc0_high_out,
  output logic [TW-1:0] vc1_low_out,
  output logic [TW-1:0] vc1_high_out,
  output logic [TW-1:0] d0_low_out,
  output logic [TW-1:0] d0_high_out,
  output logic [TW-1:0] d1_low_out,
  output logic [TW-1:0] d1_high_out,
  output logic [2:0]    state,
  output logic [NF-1:0] error_out,
  output logic          idle_out,
  output logic          active_out
);
  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } st_t;
  st_t st, ns;
  logic [TW-1:0] lo_in [NF];
  logic [TW-1:0] hi_in [NF];
  logic [TW-1:0] lo_q [NF];
  logic [TW-1:0] hi_q [NF];
  logic [NF-1:0] cfg_err, err_n;
  logic any_err, all_empty, load;
  assign lo_in = '{main_fifo_low, Vco_low, Vc1_low, Do_low, D1_low};
  assign hi_in = '{main_fifo_high, Vco_high, Vc1_high, Do_high, D1_high};
  assign any_err = |errors;
  assign all_empty = &empties;
  assign state = st;
  assign {main_low_out, vc0_low_out, vc1_low_out, d0_low_out, d1_low_out} = {lo_q[0], lo_q[1], lo_q[2], lo_q[3], lo_q[4]};
  assign {main_high_out, vc0_high_out, vc1_high_out, d0_high_out, d1_high_out} = {hi_q[0], hi_q[1], hi_q[2], hi_q[3], hi_q[4]};
  for (genvar i = 0; i < NF; i++) begin : g_cfg
    assign cfg_err[i] = lo_in[i] > hi_in[i];
  end
  // next state and next error vector; errors are always accumulated, config faults only when leaving INIT cleanly
  always_comb begin
    load = st == S_INIT;
    err_n = error_out | errors | ((st == S_INIT && !init && !any_err) ? cfg_err : '0);
    ns = st;
    case (st)
      S_RESET:  ns = any_err ? S_ERROR : S_INIT;
      S_INIT:   ns = any_err ? S_ERROR : init ? S_INIT : |cfg_err ? S_ERROR : S_IDLE;
      S_IDLE,
      S_ACTIVE: ns = any_err ? S_ERROR : init ? S_INIT : all_empty ? S_IDLE : S_ACTIVE;
      S_ERROR: begin
`ifdef FSM_ERR_RECOVER_EN
        if (init && !any_err) begin
          ns = S_INIT;
          err_n = '0;
        end
`else
        ns = S_ERROR;
`endif
      end
      default:  ns = S_RESET;
    endcase
  end
  // state, sticky errors, decoded status flags and threshold capture
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= S_RESET;
      lo_q <= '{default: '0};
      hi_q <= '{default: '0};
      error_out <= '0;
      idle_out <= 1'b0;
      active_out <= 1'b0;
    end else begin
      st <= ns;
      error_out <= err_n;
      idle_out <= ns == S_IDLE;
      active_out <= ns == S_ACTIVE;
      if (load) begin
        lo_q <= lo_in;
        hi_q <= hi_in;
      end
    end
  end
endmodule

// File: tb/tb_fsm_ctrl.sv
// tb_fsm_ctrl: directed and randomized checks of fsm_ctrl against a behavioural model
module tb_fsm_ctrl;
  logic clk = 1'b0;
  logic reset, init;
  logic [4:0] tlo [5];
  logic [4:0] thi [5];
  logic [4:0] empties, errors;
  logic [4:0] main_low_out, main_high_out, vc0_low_out, vc0_high_out, vc1_low_out, vc1_high_out;
  logic [4:0] d0_low_out, d0_high_out, d1_low_out, d1_high_out;
  logic [2:0] state;
  logic [4:0] error_out;
  logic idle_out, active_out;
  int checks = 0;
  int errs = 0;
  int m_st = 0;
  int m_lo [5];
  int m_hi [5];
  logic [4:0] m_err = '0;

  fsm_ctrl dut (
    .clk(clk), .reset(reset), .init(init),
    .main_fifo_low(tlo[0]), .main_fifo_high(thi[0]),
    .Vco_low(tlo[1]), .Vco_high(thi[1]),
    .Vc1_low(tlo[2]), .Vc1_high(thi[2]),
    .Do_low(tlo[3]), .Do_high(thi[3]),
    .D1_low(tlo[4]), .D1_high(thi[4]),
    .empties(empties), .errors(errors),
    .main_low_out(main_low_out), .main_high_out(main_high_out),
    .vc0_low_out(vc0_low_out), .vc0_high_out(vc0_high_out),
    .vc1_low_out(vc1_low_out), .vc1_high_out(vc1_high_out),
    .d0_low_out(d0_low_out), .d0_high_out(d0_high_out),
    .d1_low_out(d1_low_out), .d1_high_out(d1_high_out),
    .state(state), .error_out(error_out), .idle_out(idle_out), .active_out(active_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model of the control rules: 0 reset, 1 init, 2 idle, 3 active, 4 error.
  task automatic model_edge();
    logic [4:0] cfg;
    if (reset) begin
      m_st = 0;
      m_err = '0;
      for (int i = 0; i < 5; i++) begin
        m_lo[i] = 0;
        m_hi[i] = 0;
      end
      return;
    end
    cfg = '0;
    for (int i = 0; i < 5; i++) cfg[i] = int'(tlo[i]) > int'(thi[i]);
    if (m_st == 1)
      for (int i = 0; i < 5; i++) begin
        m_lo[i] = int'(tlo[i]);
        m_hi[i] = int'(thi[i]);
      end
    if (m_st == 4) begin
      m_err |= errors;
`ifdef FSM_ERR_RECOVER_EN
      if (init && errors == 0) begin
        m_st = 1;
        m_err = '0;
      end
`endif
    end else if (errors != 0) begin
      m_err |= errors;
      m_st = 4;
    end else if (m_st == 0) m_st = 1;
    else if (init) m_st = 1;
    else if (m_st == 1) begin
      m_err |= cfg;
      m_st = (cfg != 0) ? 4 : 2;
    end else m_st = (empties == 5'h1f) ? 2 : 3;
  endtask

  task automatic step(input logic r, input logic in_init, input logic [4:0] emp, input logic [4:0] err);
    logic [63:0] exp_t, got_t;
    reset = r;
    init = in_init;
    empties = emp;
    errors = err;
    @(posedge clk);
    model_edge();
    #1;
    exp_t = '0;
    for (int i = 0; i < 5; i++) exp_t = (exp_t << 10) | 64'((m_lo[i] << 5) | m_hi[i]);
    got_t = 64'({main_low_out, main_high_out, vc0_low_out, vc0_high_out, vc1_low_out, vc1_high_out,
                 d0_low_out, d0_high_out, d1_low_out, d1_high_out});
    check("state", 64'(state), 64'(m_st));
    check("error_out", 64'(error_out), 64'(m_err));
    check("idle_out", 64'(idle_out), 64'(m_st == 2));
    check("active_out", 64'(active_out), 64'(m_st == 3));
    check("thresholds", got_t, exp_t);
  endtask

  initial begin
    tlo[0] = 5'd4;
    thi[0] = 5'd20;
    for (int i = 1; i < 5; i++) begin
      tlo[i] = 5'd2;
      thi[i] = 5'd10;
    end
    step(1, 0, 5'h1f, 0);
    step(1, 0, 5'h1f, 0);
    check("rst_state", 64'(state), 64'd0);
    step(0, 1, 5'h1f, 0);
    step(0, 1, 5'h1f, 0);
    step(0, 1, 5'h1f, 0);
    check("init_state", 64'(state), 64'd1);
    step(0, 0, 5'h1f, 0);
    check("tp_idle_state", 64'(state), 64'd2);
    check("tp_main_low", 64'(main_low_out), 64'd4);
    check("tp_main_high", 64'(main_high_out), 64'd20);
    check("tp_idle_out", 64'(idle_out), 64'd1);
    step(0, 0, 5'b11110, 0);
    check("tp_active", 64'(state), 64'd3);
    step(0, 0, 5'h1f, 0);
    check("tp_back_idle", 64'(state), 64'd2);
    step(0, 0, 5'b11110, 0);
    step(0, 0, 5'b11110, 5'b00100);
    check("tp_err_state", 64'(state), 64'd4);
    step(0, 0, 5'b11110, 0);
    check("tp_err_sticky", 64'(error_out), 64'b00100);
    step(0, 0, 5'b11110, 5'b00001);
    check("tp_err_accum", 64'(error_out), 64'b00101);
    step(1, 0, 5'h1f, 0);
    check("tp_err_reset", 64'(error_out), 64'd0);
    step(0, 1, 5'h1f, 0);
    tlo[2] = 5'd12;
    thi[2] = 5'd8;
    step(0, 0, 5'h1f, 0);
    check("tp_cfg_state", 64'(state), 64'd4);
    check("tp_cfg_err", 64'(error_out), 64'b00100);
    step(1, 0, 5'h1f, 0);
    step(0, 1, 5'h1f, 0);
    tlo[2] = 5'd8;
    step(0, 0, 5'h1f, 0);
    check("tp_cfg_equal", 64'(state), 64'd2);
    step(0, 1, 5'h00, 5'b01000);
    check("tp_prio_err", 64'(state), 64'd4);
    step(1, 0, 5'h1f, 5'b01000);
    check("tp_prio_reset", 64'(state), 64'd0);
    step(0, 0, 5'h1f, 0);
    step(0, 0, 5'h1f, 0);
    step(0, 0, 5'h1f, 5'b00010);
    step(0, 1, 5'h1f, 0);
`ifdef FSM_ERR_RECOVER_EN
    check("tp_recover_state", 64'(state), 64'd1);
    check("tp_recover_err", 64'(error_out), 64'd0);
`else
    check("tp_terminal_state", 64'(state), 64'd4);
    check("tp_terminal_err", 64'(error_out), 64'b00010);
`endif
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 2) == 0)
        for (int i = 0; i < 5; i++) begin
          tlo[i] = 5'($urandom);
          thi[i] = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'($urandom_range(int'(tlo[i]), 31));
        end
      step($urandom_range(0, 24) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 1) == 0 ? 5'h1f : 5'($urandom),
           $urandom_range(0, 11) == 0 ? 5'($urandom) : 5'd0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end
endmodule
